// File: rtl/weight_mem_pkg.sv
// ============================================================================
// Module      : weight_mem_pkg
// Description : Shared constants and types for the weight/bias memory
//               responder. Holds the request-bus widths, the layer-1 image
//               map (kernel bytes followed by bias bytes), the request FIFO
//               entry layout and an address range helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package weight_mem_pkg;

    // Request bus widths
    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 32;

    // Layer-1 image map: kernel bytes first, biases packed directly behind
    localparam int W_COUNT    = 756;
    localparam int B_COUNT    = 28;
    localparam int BIAS_BASE  = W_COUNT;
    localparam int IMAGE_SIZE = W_COUNT + B_COUNT;

    // One queued request as it travels through the request FIFO
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_entry_t;

    // True when a byte address lands inside a store of 'depth' bytes
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int unsigned       depth);
        return addr < ADDR_W'(depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/weight_mem_responder_req_fifo.sv
// ============================================================================
// Module      : req_fifo
// Description : Synchronous request FIFO holding req_entry_t records.
//               Head entry is presented combinationally; occupancy is
//               exported as a registered count so the parent can derive
//               its ready signal without a combinational path.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_push        - write i_push_data (ignored when full)
//               i_push_data   - entry to enqueue
//               i_pop         - discard head entry (ignored when empty)
//               o_head        - current head entry
//               o_count       - registered occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module req_fifo
    import weight_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  req_entry_t               i_push_data,
    input  logic                     i_pop,
    output req_entry_t               o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    req_entry_t         r_slots_q [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_CNT_W-1:0] r_count_q,  w_count_d;
    logic               w_do_push, w_do_pop;

    assign w_do_push = i_push && (r_count_q != c_CNT_W'(DEPTH));
    assign w_do_pop  = i_pop  && (r_count_q != '0);

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_do_push) begin
            w_wr_ptr_d = r_wr_ptr_q + 1'b1;
        end
        if (w_do_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + 1'b1;
        end
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_d = r_count_q + 1'b1;
            2'b01:   w_count_d = r_count_q - 1'b1;
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    // Payload storage carries no reset; occupancy alone defines validity
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_slots_q[r_wr_ptr_q] <= i_push_data;
        end
    end

    assign o_head  = r_slots_q[r_rd_ptr_q];
    assign o_count = r_count_q;

endmodule

`default_nettype wire

// File: rtl/weight_mem_responder.sv
// ============================================================================
// Module      : weight_mem_responder
// Description : Byte-wide weight/bias store answering in-order read/write
//               requests queued in a small FIFO. Reads return after a fixed
//               READ_LATENCY measured from the pop cycle. A host preload
//               port writes the array directly and pre-empts queued work.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               req_valid/req_ready      - request handshake
//               req_write/addr/wdata     - request payload
//               resp_valid/resp_data     - read response (one-cycle pulse,
//                                          data holds between responses)
//               load_valid/addr/data     - host preload write, top priority
//               err_oob                  - sticky out-of-range flag
//               busy                     - queue non-empty or read in flight
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_mem_responder #(
    parameter int DEPTH        = 1024,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     resp_valid,
    output logic [DATA_W-1:0]        resp_data,
    input  logic                     load_valid,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [DATA_W-1:0]        load_data,
    output logic                     err_oob,
    output logic                     busy
);

    // The FIFO entry layout is fixed by the package; ADDR_W and DATA_W are
    // expected to keep their package values.
    import weight_mem_pkg::*;

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Storage array; deliberately not reset so it can be preloaded
    logic [DATA_W-1:0]  mem [DEPTH];

    logic [c_CNT_W-1:0] w_count;
    req_entry_t         w_push_entry;
    req_entry_t         w_head;
    logic               w_push;
    logic               w_pop;
    logic               w_head_in_range;
    logic               w_rd_fire;
    logic [DATA_W-1:0]  w_rd_data;

    logic               w_mem_we;
    logic [c_IDX_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0]  w_mem_wdata;

    // Latency pipeline: stage READ_LATENCY-1 drives the response outputs
    logic [READ_LATENCY-1:0] r_pipe_vld_q,  w_pipe_vld_d;
    logic [DATA_W-1:0]       r_pipe_data_q [READ_LATENCY];
    logic [DATA_W-1:0]       w_pipe_data_d [READ_LATENCY];
    logic [READ_LATENCY:0]   w_chain_vld;
    logic [DATA_W-1:0]       w_chain_data  [READ_LATENCY+1];

    logic r_err_oob_q, w_err_oob_d;

    // ------------------------------------------------------------------
    // Request queue
    // ------------------------------------------------------------------
    // Ready comes from the registered count only, so a pop in the same
    // cycle never opens a slot early.
    assign req_ready    = (w_count < c_CNT_W'(FIFO_DEPTH));
    assign w_push       = req_valid && req_ready;
    assign w_push_entry = '{write: req_write, addr: req_addr, wdata: req_wdata};

    req_fifo #(
        .DEPTH       (FIFO_DEPTH)
    ) u_req_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    // ------------------------------------------------------------------
    // Service: a preload owns the array for the cycle and stalls the queue
    // ------------------------------------------------------------------
    assign w_pop           = !load_valid && (w_count != '0);
    assign w_head_in_range = addr_in_range(w_head.addr, DEPTH);
    assign w_rd_fire       = w_pop && !w_head.write;
    assign w_rd_data       = w_head_in_range ? mem[w_head.addr[c_IDX_W-1:0]]
                                             : '0;

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = '0;
        w_mem_wdata = '0;
        if (load_valid) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = load_addr;
            w_mem_wdata = load_data;
        end else if (w_pop && w_head.write && w_head_in_range) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = w_head.addr[c_IDX_W-1:0];
            w_mem_wdata = w_head.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // Sticky: any popped request outside the array, read or write
    assign w_err_oob_d = r_err_oob_q || (w_pop && !w_head_in_range);

    // ------------------------------------------------------------------
    // Latency pipeline. Data is captured in the pop cycle, so later
    // preloads cannot disturb a read already in flight. Each stage only
    // loads data alongside a valid, which makes the last stage hold the
    // previous response between pulses.
    // ------------------------------------------------------------------
    always_comb begin
        w_chain_vld[0]  = w_rd_fire;
        w_chain_data[0] = w_rd_data;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_chain_vld[i+1]  = r_pipe_vld_q[i];
            w_chain_data[i+1] = r_pipe_data_q[i];
        end
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_pipe_vld_d[i]  = w_chain_vld[i];
            w_pipe_data_d[i] = w_chain_vld[i] ? w_chain_data[i] : r_pipe_data_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld_q <= '0;
            r_err_oob_q  <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe_data_q[i] <= '0;
            end
        end else begin
            r_pipe_vld_q <= w_pipe_vld_d;
            r_err_oob_q  <= w_err_oob_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe_data_q[i] <= w_pipe_data_d[i];
            end
        end
    end

    assign resp_valid = r_pipe_vld_q[READ_LATENCY-1];
    assign resp_data  = r_pipe_data_q[READ_LATENCY-1];
    assign err_oob    = r_err_oob_q;
    assign busy       = (w_count != '0) || (|r_pipe_vld_q);

endmodule

`default_nettype wire

// File: doc/weight_mem_responder.md
Name: weight_mem_responder

Overview:
- Memory-side responder for the byte-wide weight/bias request interface used by the layer loaders.
- Accepts read and write requests in order through a small request FIFO and returns read data after a fixed pipeline latency.
- Provides a host preload port with priority over queued requests, so kernel and bias images can be written while a loader is active.
- Replaces the behavioural backing memory in layer benches and is the synthesizable weight store.

Parameters:
- DEPTH, 1024, number of 8-bit storage locations
- ADDR_W, 32, request address width
- DATA_W, 8, data width
- READ_LATENCY, 1, cycles from pop to resp_valid (legal range >= 1)
- FIFO_DEPTH, 4, request queue entries (power of two, >= 2)

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  read data valid, one-cycle pulse per read
- resp_data  out  DATA_W  read data
- load_valid  in  1  host preload write, has priority
- load_addr  in  $clog2(DEPTH)  preload address
- load_data  in  DATA_W  preload data
- err_oob  out  1  sticky out-of-range flag
- busy  out  1  FIFO non-empty or read in flight

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset:
  - FIFO emptied, latency pipeline cleared.
  - req_ready=1 from the first cycle after reset; resp_valid=0, resp_data=0, err_oob=0, busy=0.
  - Storage array is not reset; it is named mem for bench backdoor $readmemh.
- Accept:
  - A request is accepted on an edge where req_valid && req_ready; it is pushed to the FIFO.
  - req_ready = (count < FIFO_DEPTH), from registered count. A simultaneous pop does not raise ready in the same cycle.
- Service, one action per cycle, with this priority:
  1. load_valid=1: mem[load_addr] <= load_data; FIFO is not popped.
  2. Otherwise, FIFO non-empty: pop the head.
     - Write: mem[addr] <= wdata; no response.
     - Read: mem[addr] is sampled in the pop cycle and enters the latency pipeline.
- Latency:
  - A read popped in cycle P gives resp_valid=1 in cycle P+READ_LATENCY, for exactly one cycle.
  - Minimum accept-to-response is READ_LATENCY+1 cycles. Example: accept in T, resp in T+2 at latency 1.
  - resp_data holds its last value when resp_valid=0.
- Ordering: strictly in order. A read queued behind a write to the same address returns the written data.
- Preload hazards:
  - A load in the same cycle a read would pop delays that read; the read then sees the loaded data.
  - Loads after a read's pop cycle do not alter its in-flight data.
- Simultaneous push and pop: count unchanged; full FIFO plus pop leaves req_ready=0 for that cycle.
- Out of range (req_addr >= DEPTH):
  - Read returns 0x00 with normal timing.
  - Write is dropped.
  - Both set err_oob; it stays set until rst.
- busy = (count != 0) || any pipeline stage valid.
- Reset mid-operation: queued and in-flight requests are discarded; no response emerges after rst deasserts.

Decomposition:
- Package weight_mem_pkg:
  - DATA_W and ADDR_W constants.
  - Layer-1 map: W_COUNT=756, B_COUNT=28, BIAS_BASE=756, derived IMAGE_SIZE=784.
  - A struct typedef for the FIFO entry {write, addr, wdata}.
- Sub-module req_fifo: synchronous FIFO holding that entry with a count output; instantiated once.
- Memory array and latency shift pipeline stay in the top module.

Test Plan:
- Preload mem[0..3]=0x01,0xFE,0x7F,0x80 via load port; read addr 2 accepted in cycle T -> resp_valid only in T+2, resp_data=0x7F, err_oob=0.
- Stream reads 0..783 with req_valid held high (layer-1 image preloaded) -> 784 responses, in order, one per cycle after the first; data matches kernel/bias files; bias[0] appears at response index 756.
- Hold load_valid 6 cycles while presenting 6 reads -> exactly 4 accepted, req_ready=0 afterwards; no resp_valid until load drops; then all 6 responses in order.
- Write 0x55 to addr 10, then read addr 10 back-to-back -> exactly one response, data 0x55.
- Read addr 1024 (DEPTH) -> resp_data=0x00 at normal latency, err_oob=1 and still 1 after 20 idle cycles.
- Issue 3 reads, assert rst for 1 cycle right after the first accept -> no resp_valid after rst, busy=0, req_ready=1; a later read of addr 0 returns preloaded 0x01.
